// File: rtl/fp32_to_int16.sv
// IEEE-754 single to signed 16-bit integer converter, truncating toward zero.
// Special and out-of-range operands take a one-edge fast path; in-range ones are shifted one bit per clock.
module fp32_to_int16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        ovf,
  output logic        inv
);

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  state_t             state_q;
  logic [4:0]         cnt_q;
  logic [23:0]        mant_q;
  logic               sign_q;
  logic signed [15:0] out_data_q;
  logic               ovf_q;
  logic               inv_q;

  logic               sign_in;
  logic [7:0]         exp_in;
  logic [22:0]        frac_in;
  logic               is_nan, is_inf, is_big, is_small, is_min;
  logic               fast_d;
  logic signed [15:0] fast_data_d;
  logic               fast_ovf_d;
  logic               fast_inv_d;
  logic [23:0]        mant_shift_d;

  function automatic logic signed [15:0] sat_value(input logic sign);
    return sign ? 16'sh8000 : 16'sh7FFF;
  endfunction

  // Magnitude never exceeds 0x7FFF, so negation cannot overflow and -0 maps to 0.
  function automatic logic signed [15:0] apply_sign(input logic sign, input logic [15:0] mag);
    return sign ? -$signed(mag) : $signed(mag);
  endfunction

  assign sign_in  = in_data[31];
  assign exp_in   = in_data[30:23];
  assign frac_in  = in_data[22:0];

  assign is_nan   = (exp_in == 8'hFF) && (frac_in != 23'd0);
  assign is_inf   = (exp_in == 8'hFF) && (frac_in == 23'd0);
  assign is_min   = (in_data == 32'hC700_0000);
  assign is_big   = (exp_in >= 8'd142) && (exp_in != 8'hFF);
  assign is_small = (exp_in < 8'd127);
  assign fast_d   = is_nan || is_inf || is_big || is_small;

  always_comb begin
    fast_data_d = 16'sd0;
    fast_ovf_d  = 1'b0;
    fast_inv_d  = 1'b0;
    if (is_nan) begin
      fast_inv_d  = 1'b1;
    end else if (is_min) begin
      fast_data_d = 16'sh8000;
    end else if (is_inf || is_big) begin
      fast_data_d = sat_value(sign_in);
      fast_ovf_d  = 1'b1;
    end
  end

  assign mant_shift_d = {1'b0, mant_q[23:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      mant_q     <= 24'd0;
      sign_q     <= 1'b0;
      out_data_q <= 16'sd0;
      ovf_q      <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= sign_in;
            mant_q <= {1'b1, frac_in};
            if (fast_d) begin
              state_q    <= OUT;
              out_data_q <= fast_data_d;
              ovf_q      <= fast_ovf_d;
              inv_q      <= fast_inv_d;
            end else begin
              state_q <= SHIFT;
              cnt_q   <= 5'(8'd150 - exp_in);
            end
          end
        end
        // One bit of right shift per edge; the final shift also forms the result.
        SHIFT: begin
          mant_q <= mant_shift_d;
          cnt_q  <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q    <= OUT;
            out_data_q <= apply_sign(sign_q, mant_shift_d[15:0]);
            ovf_q      <= 1'b0;
            inv_q      <= 1'b0;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q    <= IDLE;
            out_data_q <= 16'sd0;
            ovf_q      <= 1'b0;
            inv_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;
  assign inv       = inv_q;

endmodule

// File: tb/tb_fp32_to_int16.sv
// Bench for fp32_to_int16: directed corner vectors, back-pressure, reset abort and
// randomized operands checked against a real-arithmetic reference model.
module tb_fp32_to_int16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        ovf;
  logic        inv;

  int checks = 0;
  int errors = 0;

  fp32_to_int16 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .ovf(ovf), .inv(inv)
  );

  always #5 clk = ~clk;

  // Reference: value = 1.frac * 2^(exp-127) in real arithmetic, truncated, then saturated.
  // Latency is counted in edges after the capture edge: 0 for the fast path, 150-exp otherwise.
  task automatic model(input logic [31:0] x, output logic [15:0] d, output logic o,
                       output logic v, output int lat);
    int  e;
    real r;
    int  iv;
    e = int'(x[30:23]);
    d = 16'h0000; o = 1'b0; v = 1'b0; lat = 0;
    if (e == 255) begin
      if (x[22:0] != 0) v = 1'b1;
      else begin d = x[31] ? 16'h8000 : 16'h7FFF; o = 1'b1; end
      return;
    end
    r = (8388608.0 + real'(x[22:0])) / 8388608.0;
    if (e >= 127) for (int i = 0; i < e - 127; i++) r = r * 2.0;
    else          for (int i = 0; i < 127 - e; i++) r = r / 2.0;
    if (x[31]) r = -r;
    if (r >= 32768.0) begin d = 16'h7FFF; o = 1'b1; end
    else if (r < -32768.0) begin d = 16'h8000; o = 1'b1; end
    else begin iv = $rtoi(r); d = iv[15:0]; end
    lat = (e >= 127 && e <= 141) ? 150 - e : 0;
  endtask

  // Drives one operand from IDLE, waits for the result, holds out_ready low for
  // 'hold' cycles, then accepts. Reports observations; comparisons are done by the callers.
  task automatic run_op(input logic [31:0] x, input int hold,
                        output logic [15:0] d, output logic o, output logic v,
                        output int lat, output bit to, output bit stable, output bit idle_ok);
    in_data = x; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    to = !out_valid;
    d = out_data; o = ovf; v = inv; stable = 1'b1;
    out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== d || ovf !== o || inv !== v || in_ready !== 1'b0)
        stable = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    idle_ok = (out_valid === 1'b0) && (in_ready === 1'b1) && (ovf === 1'b0) && (inv === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h3F80_0000; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, out_data, ovf, inv} !== {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b r=%b d=%h ovf=%b inv=%b want v=0 r=1 d=0000 ovf=0 inv=0",
               out_valid, in_ready, out_data, ovf, inv);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vin [10] = '{32'h3F80_0000, 32'h42C9_0000, 32'hC030_0000, 32'h471C_4000,
                              32'hC700_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h3F00_0000,
                              32'h46FF_FE00, 32'h8000_0000};
    logic [15:0] vd [10] = '{16'h0001, 16'h0064, 16'hFFFE, 16'h7FFF, 16'h8000,
                             16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000};
    logic        vo [10] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    logic        vv [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int          vl [10] = '{23, 17, 22, 0, 0, 0, 0, 0, 9, 0};
    logic [15:0] d; logic o, v; int lat; bit to, st, idl;
    for (int i = 0; i < 10; i++) begin
      run_op(vin[i], 0, d, o, v, lat, to, st, idl);
      checks++;
      if (to || {d, o, v} !== {vd[i], vo[i], vv[i]}) begin
        errors++;
        $display("FAIL directed_result %h: got d=%h ovf=%b inv=%b to=%b want d=%h ovf=%b inv=%b",
                 vin[i], d, o, v, to, vd[i], vo[i], vv[i]);
      end
      checks++;
      if (lat != vl[i]) begin
        errors++;
        $display("FAIL directed_latency %h: got %0d want %0d", vin[i], lat, vl[i]);
      end
      checks++;
      if (!idl) begin
        errors++;
        $display("FAIL directed_accept %h: got not idle after accept want idle", vin[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d; logic o, v; int lat;
    in_data = 32'h471C_4000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 32'h3F80_0000;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h7FFF || ovf !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: got v=%b d=%h ovf=%b want v=1 d=7fff ovf=1", out_valid, out_data, ovf);
    end
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, out_data, ovf, inv} !== {1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold: got v=%b r=%b d=%h ovf=%b inv=%b want v=1 r=0 d=7fff ovf=1 inv=0",
                 out_valid, in_ready, out_data, ovf, inv);
      end
    end
    in_data = 32'h4000_0000; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_capture: got in_ready=%b want 0", in_ready);
    end
    model(32'h4000_0000, d, o, v, lat);
    for (int k = 1; k < lat; k++) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_early: got out_valid=%b one edge before due want 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== d || ovf !== o || inv !== v) begin
      errors++;
      $display("FAIL bp_second: got v=%b d=%h ovf=%b inv=%b want v=1 d=%h ovf=%b inv=%b",
               out_valid, out_data, ovf, inv, d, o, v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    bit seen;
    in_data = 32'h3F80_0000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1; rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, out_data, ovf, inv} !== {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_shift: got v=%b r=%b d=%h ovf=%b inv=%b want v=0 r=1 d=0000 ovf=0 inv=0",
               out_valid, in_ready, out_data, ovf, inv);
    end
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_abort: got out_valid pulse want none");
    end
  endtask

  task automatic test_random();
    logic [31:0] x; logic [15:0] d, ed; logic o, v, eo, ev; int lat, el, sel, hold; bit to, st, idl;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      x = $urandom;
      if (sel < 7)       x[30:23] = 8'($urandom_range(120, 150));
      else if (sel == 7) x[30:23] = 8'hFF;
      else if (sel == 8) x = {1'b1, 8'd142, 23'($urandom_range(0, 1))};
      hold = $urandom_range(0, 3);
      model(x, ed, eo, ev, el);
      run_op(x, hold, d, o, v, lat, to, st, idl);
      checks++;
      if (to || {d, o, v} !== {ed, eo, ev} || lat != el) begin
        errors++;
        $display("FAIL rand_result %h: got d=%h ovf=%b inv=%b lat=%0d want d=%h ovf=%b inv=%b lat=%0d",
                 x, d, o, v, lat, ed, eo, ev, el);
      end
      checks++;
      if (!st || !idl) begin
        errors++;
        $display("FAIL rand_handshake %h: got stable=%b idle=%b want 1 1", x, st, idl);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
